mips_cpu_pc_sequencer: RTL and testbench
========================================

# mips_cpu_pc_sequencer

Program-counter and control-flow sequencer for the MIPS CPU. It consumes the ALU's branch decision (`sig_branch`, `link`) together with the decoded jump fields. It owns the PC register, implements the architectural branch delay slot, produces link-register write data for JAL/JALR/BGEZAL/BLTZAL, and detects the halt condition (control transfer to address 0). It sits between the ALU/decoder and the instruction-fetch address, and advances once per committed instruction.

## Interface
Parameters:
- `RESET_VECTOR`, 32'hBFC0_0000, PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `advance`  in  1  commit strobe: the instruction at `pc` completes this cycle.
- `opcode`  in  6  opcode of the committing instruction.
- `funct`  in  6  funct field (valid when `opcode`==0).
- `rd_index`  in  5  rd field (JALR link destination).
- `immediate`  in  16  branch offset.
- `jump_index`  in  26  J/JAL target index.
- `rs_content`  in  32  rs value (JR/JALR target).
- `sig_branch`  in  1  ALU branch-taken decision for conditional branches.
- `link`  in  1  ALU link request; sampled only when `opcode`==6'h01.
- `pc`  out  32  address of the current instruction (registered).
- `active`  out  1  high while executing; low once halted.
- `in_delay_slot`  out  1  current instruction is a delay slot (registered).
- `link_we`  out  1  write `link_addr` into register `link_reg` this cycle.
- `link_reg`  out  5  31 for JAL/BGEZAL/BLTZAL; `rd_index` for JALR.
- `link_addr`  out  32  `pc`+8, modulo 2^32.
- `align_fault`  out  1  sticky misaligned-target flag (see Configuration).

## Operation
- States: SEQ (no pending transfer), DELAY (transfer latched, delay slot executing), HALTED.
- Control transfers: BEQ/BNE/BLEZ/BGTZ/REGIMM (opcode 1) taken when `sig_branch`=1; J, JAL unconditional; JR (funct 08), JALR (funct 09) unconditional.
- Targets:
  - branch: `pc`+4+(sext(immediate)<<2);
  - J/JAL: {(`pc`+4)[31:28], `jump_index`, 2'b00};
  - JR/JALR: `rs_content`.
- All additions wrap modulo 2^32.
- SEQ, `advance`, taken transfer: latch target, `pc`<=`pc`+4, go to DELAY.
- SEQ, `advance`, no transfer: `pc`<=`pc`+4.
- DELAY, `advance`: `pc`<=latched target.
  - If latched target == 0, go to HALTED.
  - Otherwise go to SEQ.
  - A control transfer inside a delay slot is ignored; the latched target wins, and the slot's own link write still occurs.
- HALTED: `pc` frozen, `active`=0, `link_we`=0. Only `reset` exits.
- `advance`=0: all state holds.
- Link (combinational, qualified by `advance` and `active`): `link_we`=1 for JAL, JALR, and opcode 1 with `link`=1.
  - BGEZAL/BLTZAL link only when taken, per the ALU's `link`.
  - `link_reg`=0 is a legal JALR destination; the register file discards it.

## Timing
- Reset values: `pc`=`RESET_VECTOR`, state SEQ, `active`=1, `in_delay_slot`=0, `align_fault`=0, latched target=0.
- `link_we`/`link_reg`/`link_addr` are combinational from current inputs and `pc`; they are valid in the commit cycle.
- `pc`, `active`, `in_delay_slot` update on the edge ending an `advance` cycle; latency is 1 cycle.
- `reset` asserted in any state (including DELAY) discards the pending target and overrides `advance`.

## Configuration
- `PC_ALIGN_CHECK_EN` defined: a taken JR/JALR with `rs_content`[1:0]!=0 sets `align_fault` and enters HALTED at the delay-slot commit instead of loading the target.
- `PC_ALIGN_CHECK_EN` undefined: the target is loaded verbatim and `align_fault` is tied 0.

## Structure
- Shared package `mips_cpu_pkg`:
  - opcode constants (REGIMM, J, JAL, BEQ, BNE, BLEZ, BGTZ);
  - funct constants (JR, JALR);
  - `RESET_VECTOR` default;
  - state enum `pc_state_t`.
- Sub-module `mips_cpu_pc_target`: combinational target and `is_transfer` computation. The parent holds the FSM, registers and link logic.

## Test plan
- Reset, then 3 non-branch commits → `pc`=BFC00000, BFC00004, BFC00008, BFC0000C; `link_we`=0 throughout.
- BEQ at BFC00010, imm=16'h0003, `sig_branch`=1 → next `pc`=BFC00014 with `in_delay_slot`=1, then BFC00020.
- BGEZAL at BFC00000, `link`=1, taken → `link_we`=1, `link_reg`=31, `link_addr`=BFC00008 in the commit cycle.
- JR with `rs_content`=0, then delay-slot commit → `active` falls; `pc`=0 held for 10 further `advance` cycles.
- JAL followed by a taken BNE in its delay slot → BNE is ignored and `pc` reaches the JAL target; reset asserted while in DELAY → `pc`=BFC00000 and the pending target is lost.
- With `PC_ALIGN_CHECK_EN`: JR with `rs_content`=32'h0000_1002 → `align_fault`=1 and `active`=0 after the slot. Without the macro → `pc`=32'h0000_1002.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - shared opcode/funct constants, reset vector and PC sequencer state type
package mips_cpu_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
  localparam logic [4:0]  LINK_REG_RA          = 5'd31;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_DELAY  = 2'd1,
    PC_HALTED = 2'd2
  } pc_state_t;

  // JAL, JALR and REGIMM-with-link all write a return address.
  function automatic logic is_link_instr(input logic [5:0] opcode,
                                         input logic [5:0] funct,
                                         input logic       link);
    return (opcode == OP_JAL) ||
           ((opcode == OP_SPECIAL) && (funct == FN_JALR)) ||
           ((opcode == OP_REGIMM) && link);
  endfunction

endpackage

// File: rtl/mips_cpu_pc_target.sv
// rtl/mips_cpu_pc_target.sv - combinational control-transfer target and taken decision (PC_ALIGN_CHECK_EN adds misaligned output)
module mips_cpu_pc_target
  import mips_cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [15:0] immediate,
  input  logic [25:0] jump_index,
  input  logic [31:0] rs_content,
  input  logic        sig_branch,
`ifdef PC_ALIGN_CHECK_EN
  output logic        misaligned,
`endif
  output logic [31:0] target,
  output logic        is_transfer
);

  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;

  // Decode the committing instruction into a target address and taken flag.
  always_comb begin
    pc_plus4    = pc + 32'd4;
    br_target   = pc_plus4 + {{14{immediate[15]}}, immediate, 2'b00};
    j_target    = {pc_plus4[31:28], jump_index, 2'b00};
    target      = br_target;
    is_transfer = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        if ((funct == FN_JR) || (funct == FN_JALR)) begin
          target      = rs_content;
          is_transfer = 1'b1;
        end
      end
      OP_J, OP_JAL: begin
        target      = j_target;
        is_transfer = 1'b1;
      end
      OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        is_transfer = sig_branch;
      end
      default: ;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  // Only register jumps can carry a non-word-aligned target.
  assign misaligned = (opcode == OP_SPECIAL) &&
                      ((funct == FN_JR) || (funct == FN_JALR)) &&
                      (rs_content[1:0] != 2'b00);
`endif

endmodule

// File: rtl/mips_cpu_pc_sequencer.sv
// rtl/mips_cpu_pc_sequencer.sv - PC register, delay-slot FSM, link and halt logic (PC_ALIGN_CHECK_EN enables align_fault)
module mips_cpu_pc_sequencer
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  rd_index,
  input  logic [15:0] immediate,
  input  logic [25:0] jump_index,
  input  logic [31:0] rs_content,
  input  logic        sig_branch,
  input  logic        link,
  output logic [31:0] pc,
  output logic        active,
  output logic        in_delay_slot,
  output logic        link_we,
  output logic [4:0]  link_reg,
  output logic [31:0] link_addr,
  output logic        align_fault
);

  pc_state_t   state_q;
  logic [31:0] pc_q;
  logic [31:0] target_q;
  logic        active_q;
  logic        in_delay_slot_q;
  logic [31:0] pc_seq_d;
  logic [31:0] target_d;
  logic        is_transfer_d;

`ifdef PC_ALIGN_CHECK_EN
  logic        misaligned_d;
  logic        misaligned_q;
  logic        align_fault_q;
`endif

  mips_cpu_pc_target u_target (
    .pc          (pc_q),
    .opcode      (opcode),
    .funct       (funct),
    .immediate   (immediate),
    .jump_index  (jump_index),
    .rs_content  (rs_content),
    .sig_branch  (sig_branch),
`ifdef PC_ALIGN_CHECK_EN
    .misaligned  (misaligned_d),
`endif
    .target      (target_d),
    .is_transfer (is_transfer_d)
  );

  assign pc_seq_d = pc_q + 32'd4;

  // Sequencer FSM: latch a transfer in SEQ, apply it after the delay slot commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= PC_SEQ;
      pc_q            <= RESET_VECTOR;
      target_q        <= 32'd0;
      active_q        <= 1'b1;
      in_delay_slot_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      misaligned_q    <= 1'b0;
      align_fault_q   <= 1'b0;
`endif
    end else if (advance) begin
      case (state_q)
        PC_SEQ: begin
          pc_q <= pc_seq_d;
          if (is_transfer_d) begin
            target_q        <= target_d;
            in_delay_slot_q <= 1'b1;
            state_q         <= PC_DELAY;
`ifdef PC_ALIGN_CHECK_EN
            misaligned_q    <= misaligned_d;
`endif
          end
        end
        PC_DELAY: begin
          // Any transfer decoded in the slot itself is deliberately ignored.
          in_delay_slot_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
          if (misaligned_q) begin
            align_fault_q <= 1'b1;
            active_q      <= 1'b0;
            state_q       <= PC_HALTED;
          end else
`endif
          if (target_q == 32'd0) begin
            pc_q     <= target_q;
            active_q <= 1'b0;
            state_q  <= PC_HALTED;
          end else begin
            pc_q    <= target_q;
            state_q <= PC_SEQ;
          end
        end
        PC_HALTED: ;
        default: state_q <= PC_HALTED;
      endcase
    end
  end

  // Link write is valid in the commit cycle, including inside a delay slot.
  always_comb begin
    link_we   = advance && active_q && is_link_instr(opcode, funct, link);
    link_reg  = LINK_REG_RA;
    if ((opcode == OP_SPECIAL) && (funct == FN_JALR)) begin
      link_reg = rd_index;
    end
    link_addr = pc_q + 32'd8;
  end

  assign pc            = pc_q;
  assign active        = active_q;
  assign in_delay_slot = in_delay_slot_q;

`ifdef PC_ALIGN_CHECK_EN
  assign align_fault = align_fault_q;
`else
  assign align_fault = 1'b0;
`endif

endmodule

// File: tb/tb_mips_cpu_pc_sequencer.sv
// tb/tb_mips_cpu_pc_sequencer.sv - scoreboard bench for mips_cpu_pc_sequencer (honours PC_ALIGN_CHECK_EN)
module tb_mips_cpu_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        advance;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rd_index;
  logic [15:0] immediate;
  logic [25:0] jump_index;
  logic [31:0] rs_content;
  logic        sig_branch;
  logic        link;
  logic [31:0] pc;
  logic        active;
  logic        in_delay_slot;
  logic        link_we;
  logic [4:0]  link_reg;
  logic [31:0] link_addr;
  logic        align_fault;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic        act;
    logic        ids;
    logic        af;
    logic        lwe;
    logic [4:0]  lreg;
    logic [31:0] laddr;
  } exp_t;

  exp_t sb_q[$];

  // Architectural reference state
  logic [31:0] m_pc;
  logic        m_pending;
  logic [31:0] m_target;
  logic        m_mis;
  logic        m_halted;
  logic        m_fault;

  mips_cpu_pc_sequencer #(.RESET_VECTOR(32'hBFC0_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .advance       (advance),
    .opcode        (opcode),
    .funct         (funct),
    .rd_index      (rd_index),
    .immediate     (immediate),
    .jump_index    (jump_index),
    .rs_content    (rs_content),
    .sig_branch    (sig_branch),
    .link          (link),
    .pc            (pc),
    .active        (active),
    .in_delay_slot (in_delay_slot),
    .link_we       (link_we),
    .link_reg      (link_reg),
    .link_addr     (link_addr),
    .align_fault   (align_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc      = 32'hBFC0_0000;
    m_pending = 1'b0;
    m_target  = 32'd0;
    m_mis     = 1'b0;
    m_halted  = 1'b0;
    m_fault   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    advance = 1'b0;
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  // Drive one cycle of inputs, push the expected observation, advance the model.
  task automatic launch(input logic adv, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] ji,
                        input logic [31:0] rs, input logic sb, input logic lk);
    exp_t        e;
    logic        tr;
    logic [31:0] tg;
    advance    = adv;
    opcode     = op;
    funct      = fn;
    rd_index   = rd;
    immediate  = imm;
    jump_index = ji;
    rs_content = rs;
    sig_branch = sb;
    link       = lk;

    e.pc    = m_pc;
    e.act   = !m_halted;
    e.ids   = m_pending;
    e.af    = m_fault;
    e.lwe   = adv && !m_halted &&
              (op == 6'd3 || (op == 6'd0 && fn == 6'd9) || (op == 6'd1 && lk));
    e.lreg  = (op == 6'd0 && fn == 6'd9) ? rd : 5'd31;
    e.laddr = m_pc + 32'd8;
    sb_q.push_back(e);

    if (adv && !m_halted) begin
      if (m_pending) begin
        m_pending = 1'b0;
        if (m_mis) begin
          m_halted = 1'b1;
          m_fault  = 1'b1;
        end else begin
          m_pc = m_target;
          if (m_target == 32'd0) m_halted = 1'b1;
        end
      end else begin
        tr = 1'b0;
        tg = 32'd0;
        if (op == 6'd0 && (fn == 6'd8 || fn == 6'd9)) begin
          tr = 1'b1;
          tg = rs;
        end else if (op == 6'd2 || op == 6'd3) begin
          tr = 1'b1;
          tg = ((m_pc + 32'd4) & 32'hF000_0000) + ({6'd0, ji} * 32'd4);
        end else if (op >= 6'd1 && op <= 6'd7 && sb) begin
          tr = 1'b1;
          tg = m_pc + 32'd4 + 32'($signed(imm)) * 32'd4;
        end
        m_pc = m_pc + 32'd4;
        if (tr) begin
          m_pending = 1'b1;
          m_target  = tg;
`ifdef PC_ALIGN_CHECK_EN
          m_mis     = (op == 6'd0) && (tg % 4 != 0);
`else
          m_mis     = 1'b0;
`endif
        end
      end
    end
  endtask

  task automatic nop();
    launch(1'b1, 6'h00, 6'h20, 5'd0, 16'd0, 26'd0, 32'd0, 1'b0, 1'b0);
    tick();
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("mon_pc", pc, e.pc);
        chk("mon_active", {31'd0, active}, {31'd0, e.act});
        chk("mon_in_delay_slot", {31'd0, in_delay_slot}, {31'd0, e.ids});
        chk("mon_align_fault", {31'd0, align_fault}, {31'd0, e.af});
        chk("mon_link_we", {31'd0, link_we}, {31'd0, e.lwe});
        if (e.lwe) begin
          chk("mon_link_reg", {27'd0, link_reg}, {27'd0, e.lreg});
          chk("mon_link_addr", link_addr, e.laddr);
        end
      end
    end
  end

  initial begin
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] rs;
    int          sel;
    reset = 1'b1; advance = 1'b0; opcode = '0; funct = '0; rd_index = '0;
    immediate = '0; jump_index = '0; rs_content = '0; sig_branch = 1'b0; link = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state and straight-line commits
    chk("rst_pc", pc, 32'hBFC0_0000);
    chk("rst_active", {31'd0, active}, 32'd1);
    chk("rst_ids", {31'd0, in_delay_slot}, 32'd0);
    chk("rst_align_fault", {31'd0, align_fault}, 32'd0);
    nop(); nop(); nop();
    chk("seq_pc3", pc, 32'hBFC0_000C);
    nop();
    chk("seq_pc4", pc, 32'hBFC0_0010);

    // Taken BEQ with delay slot
    launch(1'b1, 6'h04, 6'h00, 5'd0, 16'h0003, 26'd0, 32'd0, 1'b1, 1'b0);
    tick();
    chk("beq_slot_pc", pc, 32'hBFC0_0014);
    chk("beq_slot_ids", {31'd0, in_delay_slot}, 32'd1);
    nop();
    chk("beq_target_pc", pc, 32'hBFC0_0020);
    chk("beq_after_ids", {31'd0, in_delay_slot}, 32'd0);

    // BGEZAL link outputs in the commit cycle
    do_reset();
    launch(1'b1, 6'h01, 6'h00, 5'd0, 16'h0010, 26'd0, 32'd0, 1'b1, 1'b1);
    #1;
    chk("bgezal_link_we", {31'd0, link_we}, 32'd1);
    chk("bgezal_link_reg", {27'd0, link_reg}, 32'd31);
    chk("bgezal_link_addr", link_addr, 32'hBFC0_0008);
    tick();
    nop();
    chk("bgezal_target_pc", pc, 32'hBFC0_0044);

    // JR to address 0 halts; PC frozen under further commits
    launch(1'b1, 6'h00, 6'h08, 5'd0, 16'd0, 26'd0, 32'd0, 1'b0, 1'b0);
    tick();
    nop();
    chk("halt_active", {31'd0, active}, 32'd0);
    chk("halt_pc", pc, 32'd0);
    for (int i = 0; i < 10; i++) begin
      launch(1'b1, 6'h03, 6'h00, 5'd0, 16'd0, 26'h0000040, 32'd0, 1'b1, 1'b1);
      tick();
    end
    chk("halt_pc_held", pc, 32'd0);
    chk("halt_active_held", {31'd0, active}, 32'd0);

    // JAL with a taken BNE in its slot; then reset while in DELAY
    do_reset();
    launch(1'b1, 6'h03, 6'h00, 5'd0, 16'd0, 26'h0000040, 32'd0, 1'b0, 1'b0);
    tick();
    launch(1'b1, 6'h05, 6'h00, 5'd0, 16'h0005, 26'd0, 32'd0, 1'b1, 1'b0);
    tick();
    chk("jal_target_pc", pc, 32'hB000_0100);
    launch(1'b1, 6'h03, 6'h00, 5'd0, 16'd0, 26'h0000080, 32'd0, 1'b0, 1'b0);
    tick();
    chk("jal2_ids", {31'd0, in_delay_slot}, 32'd1);
    reset = 1'b1; advance = 1'b1; opcode = 6'h05; sig_branch = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    chk("rst_in_delay_pc", pc, 32'hBFC0_0000);
    chk("rst_in_delay_ids", {31'd0, in_delay_slot}, 32'd0);
    nop();
    chk("pending_lost_pc", pc, 32'hBFC0_0004);

    // Misaligned JR target
    do_reset();
    launch(1'b1, 6'h00, 6'h08, 5'd0, 16'd0, 26'd0, 32'h0000_1002, 1'b0, 1'b0);
    tick();
    nop();
`ifdef PC_ALIGN_CHECK_EN
    chk("align_fault_set", {31'd0, align_fault}, 32'd1);
    chk("align_halt", {31'd0, active}, 32'd0);
`else
    chk("align_verbatim_pc", pc, 32'h0000_1002);
    chk("align_fault_tied", {31'd0, align_fault}, 32'd0);
`endif

    // Randomised commits against the reference model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (m_halted && ($urandom_range(0, 3) == 0)) begin
        do_reset();
      end else begin
        sel = $urandom_range(0, 9);
        fn  = 6'h20;
        case (sel)
          0: op = 6'h00;
          1: begin op = 6'h00; fn = 6'h08; end
          2: begin op = 6'h00; fn = 6'h09; end
          3: op = 6'h01;
          4: op = 6'h02;
          5: op = 6'h03;
          6: op = 6'h04;
          7: op = 6'h05;
          8: op = ($urandom_range(0, 1) == 0) ? 6'h06 : 6'h07;
          default: op = 6'h08;
        endcase
        rs = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 7) == 0) rs = rs | 32'($urandom_range(1, 3));
        if ($urandom_range(0, 19) == 0) rs = 32'd0;
        launch($urandom_range(0, 4) != 0, op, fn, 5'($urandom), 16'($urandom),
               26'($urandom), rs, 1'($urandom), 1'($urandom));
        tick();
      end
    end

    advance = 1'b0;
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
